// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register and the redirect/stall counters.
// A redirect resolved in EX has priority over a hazard stall, and reset overrides both.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [1:0]  ex_npc_op,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);
    localparam logic [1:0] OP_SEQ = 2'b00, OP_JALR = 2'b01, OP_BR = 2'b10, OP_JAL = 2'b11;

    logic [31:0] pc, pc4, target;
    logic        redirect;

    assign pc4       = pc + 32'd4;
    assign irom_addr = pc;

    always_comb begin
        redirect = 1'b0;
        target   = ex_pc + ex_imm;
        if (ex_valid) begin
            case (ex_npc_op)
                OP_JALR: redirect = 1'b1;
                OP_BR:   redirect = ex_br_taken;
                OP_JAL:  redirect = 1'b1;
                default: redirect = 1'b0;
            endcase
        end
        // Only jalr clears bit 0; bit 1 is passed through so misalignment shows up downstream.
        if (ex_npc_op == OP_JALR)
            target = (ex_rs1 + ex_imm) & ~32'h1;
    end

    assign flush = redirect & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
            if_id_inst   <= NOP_INST;
            if_id_valid  <= 1'b0;
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else if (redirect) begin
            pc           <= target;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
            if_id_inst   <= NOP_INST;
            if_id_valid  <= 1'b0;
            redirect_cnt <= redirect_cnt + 32'd1;
        end else if (stall) begin
            stall_cnt    <= stall_cnt + 32'd1;
        end else begin
            pc           <= pc4;
            if_id_pc     <= pc;
            if_id_pc4    <= pc4;
            if_id_inst   <= irom_inst;
            if_id_valid  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-cycle inputs with hand-computed results,
// plus a short reset-hold sequence. ROM model returns the word index (addr >> 2).
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst, stall, ex_valid, ex_br_taken;
    logic [1:0]  ex_npc_op;
    logic [31:0] ex_pc, ex_imm, ex_rs1, irom_addr, irom_inst;
    logic [31:0] if_id_pc, if_id_pc4, if_id_inst, redirect_cnt, stall_cnt;
    logic        if_id_valid, flush;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign irom_inst = irom_addr >> 2;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_npc_op(ex_npc_op),
        .ex_br_taken(ex_br_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .irom_addr(irom_addr), .irom_inst(irom_inst), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .flush(flush), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        rst, stall, ev;
        logic [1:0]  op;
        logic        tk;
        logic [31:0] epc, eimm, ers1;
        logic        eflush;
        logic [31:0] pc, ipc, ipc4, iinst;
        logic        ival;
        logic [31:0] rc, sc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall = v.stall; ex_valid = v.ev; ex_npc_op = v.op;
        ex_br_taken = v.tk; ex_pc = v.epc; ex_imm = v.eimm; ex_rs1 = v.ers1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_npc_op = 2'b00; ex_br_taken = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0;

        //                rst st ev op    tk epc           eimm   ers1   flush pc            ipc           ipc4          iinst         v  rc sc
        vq.push_back(vec_t'{1, 1, 1, 2'b11, 0, 32'h100,      32'h4, 32'h0,   0, 32'h0,        32'h0,        32'h0,        32'h13,       0, 0, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h4,        32'h0,        32'h4,        32'h0,        1, 0, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h8,        32'h4,        32'h8,        32'h1,        1, 0, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'hC,        32'h8,        32'hC,        32'h2,        1, 0, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h10,       32'hC,        32'h10,       32'h3,        1, 0, 0});
        // taken branch 0x10 + 0x20
        vq.push_back(vec_t'{0, 0, 1, 2'b10, 1, 32'h10,       32'h20, 32'h0,  1, 32'h30,       32'h0,        32'h0,        32'h13,       0, 1, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h34,       32'h30,       32'h34,       32'hC,        1, 1, 0});
        // jalr 0x101 + 4 -> 0x104
        vq.push_back(vec_t'{0, 0, 1, 2'b01, 0, 32'h0,        32'h4, 32'h101, 1, 32'h104,      32'h0,        32'h0,        32'h13,       0, 2, 0});
        // not-taken branch, then jal with ex_valid low: both sequential
        vq.push_back(vec_t'{0, 0, 1, 2'b10, 0, 32'h10,       32'h20, 32'h0,  0, 32'h108,      32'h104,      32'h108,      32'h41,       1, 2, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b11, 1, 32'h10,       32'h20, 32'h0,  0, 32'h10C,      32'h108,      32'h10C,      32'h42,       1, 2, 0});
        // two stall cycles hold everything
        vq.push_back(vec_t'{0, 1, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h10C,      32'h108,      32'h10C,      32'h42,       1, 2, 1});
        vq.push_back(vec_t'{0, 1, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h10C,      32'h108,      32'h10C,      32'h42,       1, 2, 2});
        // stall + jal: redirect wins, stall not counted
        vq.push_back(vec_t'{0, 1, 1, 2'b11, 0, 32'h200,      32'h40, 32'h0,  1, 32'h240,      32'h0,        32'h0,        32'h13,       0, 3, 2});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h244,      32'h240,      32'h244,      32'h90,       1, 3, 2});
        // jal to 0x302: bit 1 passes through
        vq.push_back(vec_t'{0, 0, 1, 2'b11, 0, 32'h300,      32'h2, 32'h0,   1, 32'h302,      32'h0,        32'h0,        32'h13,       0, 4, 2});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h306,      32'h302,      32'h306,      32'hC0,       1, 4, 2});
        // jump to top of address space, then PC+4 wraps to 0
        vq.push_back(vec_t'{0, 0, 1, 2'b11, 0, 32'hFFFF_FFF0, 32'hC, 32'h0,  1, 32'hFFFF_FFFC, 32'h0,       32'h0,        32'h13,       0, 5, 2});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h3FFF_FFFF, 1, 5, 2});
        // jalr 0xFF + 0 -> 0xFE: bit 0 cleared, bit 1 kept
        vq.push_back(vec_t'{0, 0, 1, 2'b01, 0, 32'h0,        32'h0, 32'hFF,  1, 32'hFE,       32'h0,        32'h0,        32'h13,       0, 6, 2});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h102,      32'hFE,       32'h102,      32'h3F,       1, 6, 2});
        // reset during stall + redirect
        vq.push_back(vec_t'{1, 1, 1, 2'b11, 0, 32'h500,      32'h4, 32'h0,   0, 32'h0,        32'h0,        32'h0,        32'h13,       0, 0, 0});
        vq.push_back(vec_t'{0, 0, 0, 2'b00, 0, 32'h0,        32'h0, 32'h0,   0, 32'h4,        32'h0,        32'h4,        32'h0,        1, 0, 0});

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check("flush", i, 32'(flush), 32'(vq[i].eflush));
            @(posedge clk);
            #1;
            check("irom_addr",    i, irom_addr,          vq[i].pc);
            check("if_id_pc",     i, if_id_pc,           vq[i].ipc);
            check("if_id_pc4",    i, if_id_pc4,          vq[i].ipc4);
            check("if_id_inst",   i, if_id_inst,         vq[i].iinst);
            check("if_id_valid",  i, 32'(if_id_valid),   32'(vq[i].ival));
            check("redirect_cnt", i, redirect_cnt,       vq[i].rc);
            check("stall_cnt",    i, stall_cnt,          vq[i].sc);
        end

        // Hold reset for several cycles with a taken branch pending: flush stays low, state pinned.
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b1; ex_npc_op = 2'b10; ex_br_taken = 1'b1;
        ex_pc = 32'h40; ex_imm = 32'h8;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_hold_flush", 100 + c, 32'(flush), 32'h0);
            @(posedge clk);
            #1;
            check("rst_hold_pc",    100 + c, irom_addr, 32'h0);
            check("rst_hold_rcnt",  100 + c, redirect_cnt, 32'h0);
            @(negedge clk);
        end
        // Releasing reset with the branch still pending: it is taken immediately.
        rst = 1'b0;
        #1;
        check("rel_flush", 103, 32'(flush), 32'h1);
        @(posedge clk);
        #1;
        check("rel_pc",    103, irom_addr, 32'h48);
        check("rel_rcnt",  103, redirect_cnt, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction inserted on flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  load-use hazard hold request from hazard unit.
REQ-006 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-007 SHALL have port ex_npc_op  input  2  EX-stage next-PC select: 00 seq, 01 jalr, 10 branch, 11 jal.
REQ-008 SHALL have port ex_br_taken  input  1  EX-stage ALU compare result for branches.
REQ-009 SHALL have port ex_pc  input  32  PC of EX-stage instruction.
REQ-010 SHALL have port ex_imm  input  32  sign-extended immediate of EX-stage instruction.
REQ-011 SHALL have port ex_rs1  input  32  forwarded rs1 value (jalr base).
REQ-012 SHALL have port irom_addr  output  32  instruction ROM address (current PC), combinational from PC register.
REQ-013 SHALL have port irom_inst  input  32  instruction ROM data, combinational read of irom_addr.
REQ-014 SHALL have port if_id_pc / if_id_pc4 / if_id_inst  output  32 each  IF/ID register: PC, PC+4, instruction.
REQ-015 SHALL have port if_id_valid  output  1  IF/ID contents are a real instruction.
REQ-016 SHALL have port flush  output  1  combinational, high in the cycle a redirect is taken; drives ID/EX bubble.
REQ-017 SHALL have port redirect_cnt  output  32  count of taken redirects since reset.
REQ-018 SHALL have port stall_cnt  output  32  count of cycles held by stall since reset.

Function
REQ-019 SHALL compute redirect = ex_valid & (npc_op==01 | npc_op==11 | (npc_op==10 & ex_br_taken)).
REQ-020 SHALL compute target: npc_op 10/11 -> ex_pc+ex_imm; npc_op 01 -> (ex_rs1+ex_imm) & ~32'h1; all adds modulo 2^32.
REQ-021 SHALL, on redirect: PC <= target; IF/ID <= {pc=0, pc4=0, inst=NOP_INST, valid=0}; redirect_cnt += 1.
REQ-022 SHALL give redirect priority over stall; a stall coincident with redirect is ignored and not counted.
REQ-023 SHALL, on stall without redirect: hold PC and all IF/ID outputs unchanged; stall_cnt += 1.
REQ-024 SHALL, otherwise: PC <= PC+4; IF/ID <= {PC, PC+4, irom_inst, valid=1}.
REQ-025 SHALL treat npc_op 10 with ex_br_taken=0, or ex_valid=0 with any npc_op, as sequential (no flush).
REQ-026 SHALL wrap PC+4 from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-027 SHALL pass target bit 1 unmodified (misalignment not trapped); only jalr clears bit 0.
REQ-028 SHALL wrap both counters modulo 2^32.
REQ-029 SHALL have one-cycle fetch latency: instruction at PC appears on if_id_inst the cycle after PC is presented.

Reset
REQ-030 SHALL, with rst high at a clock edge, set PC=RESET_PC, IF/ID={0,0,NOP_INST,0}, both counters 0, regardless of stall/redirect.
REQ-031 SHALL drive flush low while rst is high.
REQ-032 SHALL, on first edge after rst deasserts (no stall/redirect), latch RESET_PC's instruction with if_id_valid=1.
REQ-033 SHALL discard any in-progress redirect or stall when rst asserts mid-operation; no counter update that cycle.

Verification
REQ-034 SHALL cover sequential fetch: reset, 4 cycles, ROM[i]=i -> if_id_pc 0,4,8,12; if_id_inst 0,1,2,3; valid=1.
REQ-035 SHALL cover taken branch: ex_valid=1, npc_op=10, taken=1, ex_pc=0x10, ex_imm=0x20 -> flush=1, next PC=0x30, if_id_valid=0, inst=0x13, redirect_cnt=1.
REQ-036 SHALL cover jalr: ex_rs1=0x101, ex_imm=0x4, npc_op=01 -> PC=0x104 (bit0 cleared); not-taken branch -> no flush, PC+4.
REQ-037 SHALL cover stall vs redirect: 2 stall cycles -> outputs held, stall_cnt=2; stall+jal same cycle -> redirect taken, stall_cnt unchanged.
REQ-038 SHALL cover wrap and reset: PC=0xFFFF_FFFC -> next 0x0; rst asserted during stall+redirect -> PC=RESET_PC, counters 0, if_id_valid=0.
